// File: rtl/camera_frame_writer_pkg.sv
// Shared widths, frame geometry, bank bases, FSM states and burst descriptor
// for the camera frame writer.
package camera_frame_writer_pkg;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned ADDR_W      = 21;
   localparam int unsigned LEN_W       = 8;
   localparam int unsigned WCNT_W      = 20;
   localparam int unsigned FIFO_DEPTH  = 64;
   localparam int unsigned BURST_LEN   = 16;
   localparam int unsigned FRAME_WORDS = 307200;

   localparam logic [ADDR_W-1:0] BANK0_BASE = 21'h00000;
   localparam logic [ADDR_W-1:0] BANK1_BASE = 21'h80000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_BURST,
      ST_SWAP
   } cfw_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } cfw_burst_t;

   function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
      return bank ? BANK1_BASE : BANK0_BASE;
   endfunction

endpackage

// File: rtl/camera_frame_writer_if.sv
// SDRAM controller write port: burst request/ack plus per-beat data handshake.
interface camera_frame_writer_if;
   import camera_frame_writer_pkg::*;

   logic              mem_wr_req;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [LEN_W-1:0]  mem_wr_len;
   logic              mem_wr_ack;
   logic              mem_data_req;
   logic [DATA_W-1:0] mem_wr_data;

   modport master (
      output mem_wr_req, mem_wr_addr, mem_wr_len, mem_wr_data,
      input  mem_wr_ack, mem_data_req
   );

   modport slave (
      input  mem_wr_req, mem_wr_addr, mem_wr_len, mem_wr_data,
      output mem_wr_ack, mem_data_req
   );
endinterface

// File: rtl/camera_frame_writer_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads 0 while empty.
module cfw_fifo_fwft #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset; empty-gating of the head hides stale contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = cnt_q;
endmodule

// File: rtl/camera_frame_writer.sv
// Packs captured pixels into SDRAM write bursts and ping-pongs two frame banks
// on each camera vsync rising edge.
module camera_frame_writer
   import camera_frame_writer_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_W-1:0]     pix_data,
   input  logic                  pix_valid,
   input  logic                  frame_sync,
   camera_frame_writer_if.master mem,
   output logic                  wr_bank,
   output logic                  rd_bank,
   output logic                  frame_done,
   output logic                  overflow
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W = WCNT_W + 1;

   cfw_state_e        state_q, state_d;
   cfw_burst_t        burst_q, burst_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [WCNT_W-1:0] word_q, word_d;
   logic [WCNT_W-1:0] in_cnt_q, in_cnt_d;
   logic              wr_bank_q, wr_bank_d;
   logic              flush_q, flush_d;
   logic              overflow_q, overflow_d;
   logic              req_q, req_d;
   logic              done_q, done_d;
   logic              sync_q;

   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              push, pop, drop, sync_rise;
   logic [SUM_W-1:0]  word_sum;

   // Pixels during vsync are discarded without flagging; all other refusals flag.
   assign push      = pix_valid && !frame_sync && !fifo_full &&
                      (in_cnt_q < WCNT_W'(FRAME_WORDS));
   assign drop      = pix_valid && !frame_sync && !push;
   assign pop       = mem.mem_data_req && !fifo_empty;
   assign sync_rise = frame_sync && !sync_q;
   assign word_sum  = SUM_W'(word_q) + SUM_W'(burst_q.len);

   cfw_fifo_fwft #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wr_data (pix_data),
      .pop     (pop),
      .rd_data (fifo_head),
      .count   (fifo_cnt),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      burst_d    = burst_q;
      beat_d     = beat_q;
      word_d     = word_q;
      in_cnt_d   = in_cnt_q + WCNT_W'(push);
      wr_bank_d  = wr_bank_q;
      flush_d    = flush_q | sync_rise;
      overflow_d = overflow_q | drop;

      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            if (fifo_cnt >= CNT_W'(BURST_LEN)) begin
               state_d      = ST_REQ;
               burst_d.len  = LEN_W'(BURST_LEN);
               burst_d.addr = bank_base(wr_bank_q) + ADDR_W'(word_q);
            end else if (flush_q && (fifo_cnt != '0)) begin
               state_d      = ST_REQ;
               burst_d.len  = LEN_W'(fifo_cnt);
               burst_d.addr = bank_base(wr_bank_q) + ADDR_W'(word_q);
            end else if (flush_q) begin
               state_d = ST_SWAP;
            end
         end
         ST_REQ: begin
            if (mem.mem_wr_ack) state_d = ST_BURST;
         end
         ST_BURST: begin
            if (pop) begin
               beat_d = beat_q + LEN_W'(1);
               if ((beat_q + LEN_W'(1)) == burst_q.len) begin
                  state_d = ST_IDLE;
                  word_d  = (word_sum > SUM_W'(FRAME_WORDS)) ?
                            WCNT_W'(FRAME_WORDS) : WCNT_W'(word_sum);
               end
            end
         end
         ST_SWAP: begin
            state_d    = ST_IDLE;
            wr_bank_d  = ~wr_bank_q;
            word_d     = '0;
            in_cnt_d   = WCNT_W'(push);
            overflow_d = drop;
            flush_d    = sync_rise;
         end
         default: state_d = ST_IDLE;
      endcase

      req_d  = (state_d == ST_REQ);
      done_d = (state_d == ST_SWAP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         burst_q    <= '0;
         beat_q     <= '0;
         word_q     <= '0;
         in_cnt_q   <= '0;
         wr_bank_q  <= 1'b0;
         flush_q    <= 1'b0;
         overflow_q <= 1'b0;
         req_q      <= 1'b0;
         done_q     <= 1'b0;
         sync_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         beat_q     <= beat_d;
         word_q     <= word_d;
         in_cnt_q   <= in_cnt_d;
         wr_bank_q  <= wr_bank_d;
         flush_q    <= flush_d;
         overflow_q <= overflow_d;
         req_q      <= req_d;
         done_q     <= done_d;
         sync_q     <= frame_sync;
      end
   end

   assign mem.mem_wr_req  = req_q;
   assign mem.mem_wr_addr = burst_q.addr;
   assign mem.mem_wr_len  = burst_q.len;
   assign mem.mem_wr_data = fifo_head;
   assign wr_bank         = wr_bank_q;
   assign rd_bank         = ~wr_bank_q;
   assign frame_done      = done_q;
   assign overflow        = overflow_q;
endmodule
